// File: rtl/dlfloat_mul_seq.sv
// rtl/dlfloat_mul_seq.sv - iterative multi-cycle DLFloat16 multiplier with start/done handshake
//
// Purpose: computes c_mul = a * b on DLFloat16 operands ([15] sign, [14:9] exponent
// bias 31, [8:0] fraction, exp 0 = zero, exp 63 = inf/NaN) using a shift-add datapath
// that retires one multiplier bit per cycle. The latency is fixed at 12 cycles from the
// accepted start to done, for every operand class.
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   start            in   request, accepted only while busy=0
//   a, b             in   16-bit operands, sampled on the accepted start
//   busy             out  high from the cycle after acceptance through the done cycle
//   done             out  one-cycle pulse; c_mul/exception_flags valid and held until next done
//   c_mul            out  16-bit product
//   exception_flags  out  {invalid, div_by_zero, overflow, underflow, inexact}
//
// Configuration: DLF_MUL_RNE_EN selects round-to-nearest-even; otherwise truncation.

module dlfloat_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] c_mul,
  output logic [4:0]  exception_flags
);

  localparam int          LATENCY    = 12;
  localparam int          MUL_CYCLES = LATENCY - 2;  // UNPACK and DONE take one cycle each
  localparam logic [15:0] QNAN       = 16'h7FFF;

  typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_MUL, S_DONE} state_t;

  state_t             state, state_nx;
  logic [15:0]        a_q, b_q;
  logic               sign_q;
  logic signed [7:0]  exp_q;
  logic [9:0]         sig_a;
  logic [9:0]         mul_sr;
  logic [19:0]        acc;
  logic [3:0]         cnt;
  logic               spec_q;
  logic [15:0]        spec_res_q;
  logic [4:0]         spec_flags_q;

  // Operand classification (on the latched operands)
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sgn;
  logic        spec_c;
  logic [15:0] spec_res_c;
  logic [4:0]  spec_flags_c;

  always_comb begin
    sgn    = a_q[15] ^ b_q[15];
    a_zero = (a_q[14:9] == 6'd0);
    b_zero = (b_q[14:9] == 6'd0);
    a_inf  = (a_q[14:9] == 6'h3F) && (a_q[8:0] == 9'd0);
    b_inf  = (b_q[14:9] == 6'h3F) && (b_q[8:0] == 9'd0);
    a_nan  = (a_q[14:9] == 6'h3F) && (a_q[8:0] != 9'd0);
    b_nan  = (b_q[14:9] == 6'h3F) && (b_q[8:0] != 9'd0);
    spec_c       = 1'b1;
    spec_res_c   = 16'h0000;
    spec_flags_c = 5'b00000;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      spec_res_c   = QNAN;
      spec_flags_c = 5'b10000;
    end else if (a_inf || b_inf) begin
      spec_res_c = {sgn, 6'h3F, 9'd0};
    end else if (a_zero || b_zero) begin
      spec_res_c = {sgn, 15'd0};
    end else begin
      spec_c = 1'b0;
    end
  end

  // Next accumulator value: MSB-first shift-add, so after MUL_CYCLES steps acc = sig_a * sig_b.
  logic [19:0] acc_nx;
  logic        last;

  always_comb begin
    acc_nx = {acc[18:0], 1'b0} + (mul_sr[9] ? {10'd0, sig_a} : 20'd0);
    last   = (cnt == 4'(MUL_CYCLES - 1));
  end

  // Normalise and round directly off acc_nx so the final MUL cycle also registers the result,
  // which keeps start-to-done at exactly LATENCY cycles.
  logic [9:0]        sig_n;
  logic [9:0]        disc;
  logic signed [7:0] exp_n, exp_f;
  logic              inexact_n, round_up;
  logic [10:0]       sig_r;
  logic [8:0]        frac_f;
  logic [15:0]       fin_res;
  logic [4:0]        fin_flags;

  always_comb begin
    if (acc_nx[19]) begin
      sig_n = acc_nx[19:10];
      disc  = acc_nx[9:0];
      exp_n = exp_q + 8'sd1;
    end else begin
      sig_n = acc_nx[18:9];
      disc  = {acc_nx[8:0], 1'b0};
      exp_n = exp_q;
    end
    inexact_n = |disc;
`ifdef DLF_MUL_RNE_EN
    // Guard bit decides; ties (no sticky bits) go to the even significand.
    round_up = disc[9] & ((|disc[8:0]) | sig_n[0]);
`else
    round_up = 1'b0;
`endif
    sig_r = {1'b0, sig_n} + {10'd0, round_up};
    if (sig_r[10]) begin
      frac_f = sig_r[9:1];
      exp_f  = exp_n + 8'sd1;
    end else begin
      frac_f = sig_r[8:0];
      exp_f  = exp_n;
    end
    if (exp_f > 8'sd62) begin
      fin_res   = {sign_q, 6'h3F, 9'd0};
      fin_flags = 5'b00101;
    end else if (exp_f < 8'sd1) begin
      fin_res   = {sign_q, 15'd0};
      fin_flags = 5'b00011;
    end else begin
      fin_res   = {sign_q, exp_f[5:0], frac_f};
      fin_flags = {4'b0000, inexact_n};
    end
  end

  // FSM next state and outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_UNPACK;
      end
      S_UNPACK: state_nx = S_MUL;
      S_MUL:    if (last) state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      a_q             <= 16'd0;
      b_q             <= 16'd0;
      sign_q          <= 1'b0;
      exp_q           <= 8'sd0;
      sig_a           <= 10'd0;
      mul_sr          <= 10'd0;
      acc             <= 20'd0;
      cnt             <= 4'd0;
      spec_q          <= 1'b0;
      spec_res_q      <= 16'd0;
      spec_flags_q    <= 5'd0;
      c_mul           <= 16'd0;
      exception_flags <= 5'd0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
          end
        end
        S_UNPACK: begin
          sign_q       <= sgn;
          exp_q        <= $signed({2'b00, a_q[14:9]}) + $signed({2'b00, b_q[14:9]}) - 8'sd31;
          sig_a        <= {1'b1, a_q[8:0]};
          mul_sr       <= {1'b1, b_q[8:0]};
          acc          <= 20'd0;
          cnt          <= 4'd0;
          spec_q       <= spec_c;
          spec_res_q   <= spec_res_c;
          spec_flags_q <= spec_flags_c;
        end
        S_MUL: begin
          acc    <= acc_nx;
          mul_sr <= {mul_sr[8:0], 1'b0};
          cnt    <= cnt + 4'd1;
          if (last) begin
            c_mul           <= spec_q ? spec_res_q : fin_res;
            exception_flags <= spec_q ? spec_flags_q : fin_flags;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_mul_seq.sv
// tb/tb_dlfloat_mul_seq.sv - self-checking bench for dlfloat_mul_seq
module tb_dlfloat_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        busy, done;
  logic [15:0] c_mul;
  logic [4:0]  exception_flags;

  int total = 0;
  int bad = 0;

  dlfloat_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .c_mul(c_mul), .exception_flags(exception_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [4:0]  f;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, rounded to a 10-bit significand by arithmetic.
  function automatic void ref_mul(input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] c, output logic [4:0] f);
    int     ex, ey, e, nbits, k;
    longint p, q, r, half;
    bit     s, xz, yz, xi, yi, xn, yn, inex;
    s  = x[15] ^ y[15];
    ex = int'(x[14:9]);
    ey = int'(y[14:9]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 63) && (x[8:0] == 0);
    yi = (ey == 63) && (y[8:0] == 0);
    xn = (ex == 63) && (x[8:0] != 0);
    yn = (ey == 63) && (y[8:0] != 0);
    if (xn || yn || (xi && yz) || (xz && yi)) begin c = 16'h7FFF; f = 5'b10000; return; end
    if (xi || yi) begin c = {s, 15'h7E00}; f = 5'b00000; return; end
    if (xz || yz) begin c = {s, 15'h0000}; f = 5'b00000; return; end
    p = longint'(512 + int'(x[8:0])) * longint'(512 + int'(y[8:0]));
    nbits = 0;
    while ((p >> nbits) != 0) nbits++;
    k = nbits - 10;
    e = ex + ey - 31 + (nbits - 19);
    q = p >> k;
    r = p - (q << k);
    inex = (r != 0);
`ifdef DLF_MUL_RNE_EN
    half = longint'(1) << (k - 1);
    if (r > half || (r == half && q[0])) q++;
`else
    half = 0;
`endif
    if (q == 1024) begin q = 512; e++; end
    if (e > 62) begin c = {s, 15'h7E00}; f = 5'b00101; end
    else if (e < 1) begin c = {s, 15'h0000}; f = 5'b00011; end
    else begin c = {s, e[5:0], q[8:0]}; f = {4'b0000, inex}; end
  endfunction

  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] c, output logic [4:0] f, output int lat);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    c = c_mul;
    f = exception_flags;
  endtask

  initial begin
    vec_t        tbl[14];
    logic [15:0] rc, x, y, ec;
    logic [4:0]  rf, ef;
    int          lat, seen;

    tbl[0]  = '{16'h3f00, 16'h4000, 16'h4100, 5'b00000};
    tbl[1]  = '{16'h3e00, 16'h3e00, 16'h3e00, 5'b00000};
    tbl[2]  = '{16'hbe00, 16'h7e00, 16'hfe00, 5'b00000};
    tbl[3]  = '{16'h7e00, 16'h0000, 16'h7fff, 5'b10000};
    tbl[4]  = '{16'h7e01, 16'h3e00, 16'h7fff, 5'b10000};
    tbl[5]  = '{16'h7c00, 16'h7c00, 16'h7e00, 5'b00101};
    tbl[6]  = '{16'h0200, 16'h0200, 16'h0000, 5'b00011};
    tbl[7]  = '{16'h3e01, 16'h3e01, 16'h3e02, 5'b00001};
    tbl[8]  = '{16'h3f00, 16'h3f00, 16'h4040, 5'b00000};
    tbl[9]  = '{16'hbf00, 16'h4000, 16'hc100, 5'b00000};
    tbl[10] = '{16'h8000, 16'h3e00, 16'h8000, 5'b00000};
    tbl[11] = '{16'h0000, 16'hfe00, 16'h7fff, 5'b10000};
    tbl[12] = '{16'hc000, 16'hc000, 16'h4200, 5'b00000};
    tbl[13] = '{16'hffff, 16'h0000, 16'h7fff, 5'b10000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_c", 32'(c_mul), 32'd0);
    chk("reset_flags", 32'(exception_flags), 32'd0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].a, tbl[i].b, rc, rf, lat);
      chk($sformatf("tbl%0d_c", i), 32'(rc), 32'(tbl[i].c));
      chk($sformatf("tbl%0d_flags", i), 32'(rf), 32'(tbl[i].f));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd12);
      @(negedge clk);
      chk($sformatf("tbl%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("tbl%0d_idle", i), 32'(busy), 32'd0);
    end

    // Start held high while busy with other operands: must not disturb the first op
    @(negedge clk);
    a = 16'h3f00; b = 16'h4000; start = 1'b1;
    @(negedge clk);
    chk("busy_after_accept", 32'(busy), 32'd1);
    a = 16'h7e01; b = 16'h0000;
    lat = 1;
    repeat (3) begin @(negedge clk); lat++; end
    start = 1'b0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    chk("busy_ign_c", 32'(c_mul), 32'h4100);
    chk("busy_ign_flags", 32'(exception_flags), 32'd0);
    chk("busy_ign_lat", 32'(lat), 32'd12);

    // Start in the DONE cycle is ignored
    start = 1'b1; a = 16'h7e01; b = 16'h3e00;
    @(negedge clk);
    start = 1'b0;
    chk("done_cycle_start_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (16) begin @(negedge clk); if (done) seen = 1; end
    chk("done_cycle_start_ignored", 32'(seen), 32'd0);
    chk("done_cycle_held_c", 32'(c_mul), 32'h4100);

    // Start in the cycle right after done is accepted
    run_op(16'h3e01, 16'h3e01, rc, rf, lat);
    chk("b2b_first_c", 32'(rc), 32'h3e02);
    @(negedge clk);
    a = 16'h3e00; b = 16'hbe00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    chk("b2b_lat", 32'(lat), 32'd12);
    chk("b2b_c", 32'(c_mul), 32'hbe00);

    // Reset during MUL cycle 5 aborts with no done
    @(negedge clk);
    a = 16'h7c00; b = 16'h7c00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (lat < 6) begin @(negedge clk); lat++; end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_c", 32'(c_mul), 32'd0);
    chk("abort_flags", 32'(exception_flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (done) seen = 1; end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op(16'h3f00, 16'h4000, rc, rf, lat);
    chk("post_abort_c", 32'(rc), 32'h4100);
    chk("post_abort_lat", 32'(lat), 32'd12);

    // Randomised operands against the reference
    for (int i = 0; i < 300; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 3) != 0) x[14:9] = 6'($urandom_range(14, 48));
      if ($urandom_range(0, 3) != 0) y[14:9] = 6'($urandom_range(14, 48));
      ref_mul(x, y, ec, ef);
      run_op(x, y, rc, rf, lat);
      chk($sformatf("rnd%0d_%h_%h_c", i, x, y), 32'(rc), 32'(ec));
      chk($sformatf("rnd%0d_%h_%h_flags", i, x, y), 32'(rf), 32'(ef));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd12);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
